// File: rtl/alu_issue_queue_pkg.sv
// ============================================================================
// alu_issue_queue_pkg : instruction field layout, register numbers, flag bits
// Revision: 1.0
// ============================================================================
`default_nettype none

package alu_issue_queue_pkg;

  localparam int c_OP_HI    = 31;
  localparam int c_OP_LO    = 26;
  localparam int c_RS_HI    = 25;
  localparam int c_RS_LO    = 21;
  localparam int c_RT_HI    = 20;
  localparam int c_RT_LO    = 16;
  localparam int c_RD_HI    = 15;
  localparam int c_RD_LO    = 11;
  localparam int c_SHAMT_HI = 10;
  localparam int c_SHAMT_LO = 6;
  localparam int c_FUNCT_HI = 5;
  localparam int c_FUNCT_LO = 0;
  localparam int c_IMM_HI   = 15;
  localparam int c_IMM_LO   = 0;

  localparam logic [4:0] c_RS_NUM = 5'd0;
  localparam logic [4:0] c_RT_NUM = 5'd1;
  localparam logic [4:0] c_RD_NUM = 5'd8;

  localparam int c_FLAG_ZERO = 2;
  localparam int c_FLAG_NEG  = 1;
  localparam int c_FLAG_OVF  = 0;

  typedef enum logic [5:0] {
    OP_RTYPE = 6'h00,
    OP_ADDI  = 6'h08,
    OP_ADDIU = 6'h09,
    OP_SLTI  = 6'h0A,
    OP_SLTIU = 6'h0B,
    OP_ANDI  = 6'h0C,
    OP_ORI   = 6'h0D,
    OP_XORI  = 6'h0E,
    OP_LUI   = 6'h0F
  } op_e;

  typedef enum logic [5:0] {
    FN_SLL  = 6'h00,
    FN_SRL  = 6'h02,
    FN_SRA  = 6'h03,
    FN_ADD  = 6'h20,
    FN_ADDU = 6'h21,
    FN_SUB  = 6'h22,
    FN_SUBU = 6'h23,
    FN_AND  = 6'h24,
    FN_OR   = 6'h25,
    FN_XOR  = 6'h26,
    FN_NOR  = 6'h27,
    FN_SLT  = 6'h2A,
    FN_SLTU = 6'h2B
  } funct_e;

  function automatic logic [31:0] encode_instr(input logic [5:0]  op,
                                               input logic [5:0]  funct,
                                               input logic [4:0]  shamt,
                                               input logic [15:0] imm);
    if (op == OP_RTYPE)
      return {op, c_RS_NUM, c_RT_NUM, c_RD_NUM, shamt, funct};
    else
      return {op, c_RS_NUM, c_RT_NUM, imm};
  endfunction

  function automatic logic add_ovf(input logic [31:0] a, input logic [31:0] b,
                                   input logic [31:0] r);
    return (a[31] == b[31]) && (r[31] != a[31]);
  endfunction

  function automatic logic sub_ovf(input logic [31:0] a, input logic [31:0] b,
                                   input logic [31:0] r);
    return (a[31] != b[31]) && (r[31] != a[31]);
  endfunction

endpackage

`default_nettype wire

// File: rtl/alu_issue_queue_alu.sv
// ============================================================================
// alu : combinational MIPS-style ALU, result plus {zero, negative, overflow}
// Revision: 1.0
// ============================================================================
`default_nettype none

module alu
  import alu_issue_queue_pkg::*;
(
  input  logic [31:0] i_instr,
  input  logic [31:0] i_rega,
  input  logic [31:0] i_regb,
  output logic [31:0] o_result,
  output logic [2:0]  o_flags
);

  logic [5:0]  w_op;
  logic [5:0]  w_funct;
  logic [4:0]  w_shamt;
  logic [15:0] w_imm;
  logic [31:0] w_simm;
  logic [31:0] w_zimm;
  logic [31:0] w_res;
  logic        w_ovf;
  logic        w_unused;

  assign w_op    = i_instr[c_OP_HI:c_OP_LO];
  assign w_funct = i_instr[c_FUNCT_HI:c_FUNCT_LO];
  assign w_shamt = i_instr[c_SHAMT_HI:c_SHAMT_LO];
  assign w_imm   = i_instr[c_IMM_HI:c_IMM_LO];
  assign w_simm  = {{16{w_imm[15]}}, w_imm};
  assign w_zimm  = {16'd0, w_imm};
  // Register numbers are fixed, so the rs/rt fields carry no information here.
  assign w_unused = &{1'b0, i_instr[c_RS_HI:c_RT_LO]};

  always_comb begin
    w_res = '0;
    w_ovf = 1'b0;
    if (w_op == OP_RTYPE) begin
      case (w_funct)
        FN_SLL:  w_res = i_regb << w_shamt;
        FN_SRL:  w_res = i_regb >> w_shamt;
        FN_SRA:  w_res = $unsigned($signed(i_regb) >>> w_shamt);
        FN_ADD:  begin
          w_res = i_rega + i_regb;
          w_ovf = add_ovf(i_rega, i_regb, w_res);
        end
        FN_ADDU: w_res = i_rega + i_regb;
        FN_SUB:  begin
          w_res = i_rega - i_regb;
          w_ovf = sub_ovf(i_rega, i_regb, w_res);
        end
        FN_SUBU: w_res = i_rega - i_regb;
        FN_AND:  w_res = i_rega & i_regb;
        FN_OR:   w_res = i_rega | i_regb;
        FN_XOR:  w_res = i_rega ^ i_regb;
        FN_NOR:  w_res = ~(i_rega | i_regb);
        FN_SLT:  w_res = {31'd0, ($signed(i_rega) < $signed(i_regb))};
        FN_SLTU: w_res = {31'd0, (i_rega < i_regb)};
        default: w_res = '0;
      endcase
    end else begin
      case (w_op)
        OP_ADDI:  begin
          w_res = i_rega + w_simm;
          w_ovf = add_ovf(i_rega, w_simm, w_res);
        end
        OP_ADDIU: w_res = i_rega + w_simm;
        OP_SLTI:  w_res = {31'd0, ($signed(i_rega) < $signed(w_simm))};
        OP_SLTIU: w_res = {31'd0, (i_rega < w_simm)};
        OP_ANDI:  w_res = i_rega & w_zimm;
        OP_ORI:   w_res = i_rega | w_zimm;
        OP_XORI:  w_res = i_rega ^ w_zimm;
        OP_LUI:   w_res = {w_imm, 16'd0};
        default:  w_res = '0;
      endcase
    end
  end

  assign o_result               = w_res;
  assign o_flags[c_FLAG_ZERO]   = (w_res == 32'd0);
  assign o_flags[c_FLAG_NEG]    = w_res[31];
  assign o_flags[c_FLAG_OVF]    = w_ovf;

endmodule

`default_nettype wire

// File: rtl/alu_issue_queue.sv
// ============================================================================
// alu_issue_queue : tagged request FIFO feeding one ALU, registered response
// Revision: 1.0
// ============================================================================
`default_nettype none

module alu_issue_queue
  import alu_issue_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TAGW  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [5:0]               req_op,
  input  logic [5:0]               req_funct,
  input  logic [4:0]               req_shamt,
  input  logic [15:0]              req_imm,
  input  logic [31:0]              req_a,
  input  logic [31:0]              req_b,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [31:0]              rsp_result,
  output logic [2:0]               rsp_flags,
  output logic [TAGW-1:0]          rsp_tag,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int                c_AW       = $clog2(DEPTH);
  localparam logic [c_AW:0]     c_DEPTH    = (c_AW+1)'(DEPTH);
  localparam logic [c_AW:0]     c_CNT_ONE  = (c_AW+1)'(1);
  localparam logic [c_AW-1:0]   c_PTR_ONE  = c_AW'(1);
  localparam logic [TAGW-1:0]   c_TAG_ONE  = TAGW'(1);

  logic [31:0]     r_instr_q [DEPTH];
  logic [31:0]     r_a_q     [DEPTH];
  logic [31:0]     r_b_q     [DEPTH];
  logic [TAGW-1:0] r_tag_q   [DEPTH];

  logic [c_AW-1:0] r_wptr;
  logic [c_AW-1:0] r_rptr;
  logic [c_AW:0]   r_count;
  logic [TAGW-1:0] r_tag;
  logic            r_rsp_valid;
  logic [31:0]     r_rsp_result;
  logic [2:0]      r_rsp_flags;
  logic [TAGW-1:0] r_rsp_tag;

  logic            w_push;
  logic            w_pop;
  logic [31:0]     w_alu_result;
  logic [2:0]      w_alu_flags;

  // Full means no accept, even if the head leaves on the same edge.
  assign req_ready = (r_count < c_DEPTH);
  assign w_push    = req_valid & req_ready;
  assign w_pop     = (r_count != '0) & (~r_rsp_valid | rsp_ready);

  alu u_alu (
    .i_instr  (r_instr_q[r_rptr]),
    .i_rega   (r_a_q[r_rptr]),
    .i_regb   (r_b_q[r_rptr]),
    .o_result (w_alu_result),
    .o_flags  (w_alu_flags)
  );

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_instr_q[r_wptr] <= encode_instr(req_op, req_funct, req_shamt, req_imm);
      r_a_q[r_wptr]     <= req_a;
      r_b_q[r_wptr]     <= req_b;
      r_tag_q[r_wptr]   <= r_tag;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr       <= '0;
      r_rptr       <= '0;
      r_count      <= '0;
      r_tag        <= '0;
      r_rsp_valid  <= 1'b0;
      r_rsp_result <= '0;
      r_rsp_flags  <= '0;
      r_rsp_tag    <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + c_PTR_ONE;
        r_tag  <= r_tag + c_TAG_ONE;
      end
      if (w_pop) begin
        r_rptr       <= r_rptr + c_PTR_ONE;
        r_rsp_valid  <= 1'b1;
        r_rsp_result <= w_alu_result;
        r_rsp_flags  <= w_alu_flags;
        r_rsp_tag    <= r_tag_q[r_rptr];
      end else if (rsp_ready) begin
        r_rsp_valid  <= 1'b0;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_CNT_ONE;
        2'b01:   r_count <= r_count - c_CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  assign rsp_valid  = r_rsp_valid;
  assign rsp_result = r_rsp_result;
  assign rsp_flags  = r_rsp_flags;
  assign rsp_tag    = r_rsp_tag;
  assign count      = r_count;

endmodule

`default_nettype wire

// File: tb/tb_alu_issue_queue.sv
// Scoreboard bench for alu_issue_queue: directed corner cases plus random traffic
// checked against a plain-arithmetic ALU model.
`default_nettype none

module tb_alu_issue_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [5:0]  req_op;
  logic [5:0]  req_funct;
  logic [4:0]  req_shamt;
  logic [15:0] req_imm;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_result;
  logic [2:0]  rsp_flags;
  logic [3:0]  rsp_tag;
  logic [2:0]  count;

  always #5 clk = ~clk;

  alu_issue_queue #(.DEPTH(4), .TAGW(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_funct  (req_funct),
    .req_shamt  (req_shamt),
    .req_imm    (req_imm),
    .req_a      (req_a),
    .req_b      (req_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_flags  (rsp_flags),
    .rsp_tag    (rsp_tag),
    .count      (count)
  );

  typedef struct {
    logic [31:0] res;
    logic [2:0]  flags;
    logic [3:0]  tag;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          n_acc    = 0;
  int          n_rsp    = 0;
  logic [3:0]  m_tag    = 4'd0;
  logic [3:0]  last_tag = 4'd0;
  logic        hold     = 1'b0;
  logic [31:0] h_res;
  logic [2:0]  h_flags;
  logic [3:0]  h_tag;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference ALU from the instruction-set definitions, using wide signed math.
  task automatic alu_model(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] sh,
                           input logic [15:0] imm, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] res, output logic [2:0] flags);
    longint sa   = $signed(a);
    longint sb_  = $signed(b);
    longint si   = $signed(imm);
    longint lmax = 2147483647;
    longint s;
    logic   ovf  = 1'b0;
    logic [31:0] se = {{16{imm[15]}}, imm};
    res = 32'd0;
    if (op == 6'd0) begin
      case (fn)
        6'h00: res = b << sh;
        6'h02: res = b >> sh;
        6'h03: begin s = sb_ / (longint'(1) << sh); if (sb_ < 0 && (sb_ % (longint'(1) << sh)) != 0) s = s - 1; res = s[31:0]; end
        6'h20: begin s = sa + sb_; res = s[31:0]; ovf = (s > lmax) || (s < -lmax - 1); end
        6'h21: res = a + b;
        6'h22: begin s = sa - sb_; res = s[31:0]; ovf = (s > lmax) || (s < -lmax - 1); end
        6'h23: res = a - b;
        6'h24: res = a & b;
        6'h25: res = a | b;
        6'h26: res = a ^ b;
        6'h27: res = ~(a | b);
        6'h2A: res = (sa < sb_) ? 32'd1 : 32'd0;
        6'h2B: res = (a < b) ? 32'd1 : 32'd0;
        default: res = 32'd0;
      endcase
    end else begin
      case (op)
        6'h08: begin s = sa + si; res = s[31:0]; ovf = (s > lmax) || (s < -lmax - 1); end
        6'h09: res = a + se;
        6'h0A: res = (sa < si) ? 32'd1 : 32'd0;
        6'h0B: res = (a < se) ? 32'd1 : 32'd0;
        6'h0C: res = a & {16'd0, imm};
        6'h0D: res = a | {16'd0, imm};
        6'h0E: res = a ^ {16'd0, imm};
        6'h0F: res = {imm, 16'd0};
        default: res = 32'd0;
      endcase
    end
    flags = {(res == 32'd0), res[31], ovf};
  endtask

  // Monitor and acceptance recorder; sampled mid-cycle, away from the active edge.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      hold = 1'b0;
    end else begin
      check("occupancy", 64'(int'(count) + int'(rsp_valid)), 64'(sb.size()));
      check("req_ready", 64'(req_ready), 64'(count < 3'd4));
      if (hold) begin
        check("hold_valid",  64'(rsp_valid),  64'd1);
        check("hold_result", 64'(rsp_result), 64'(h_res));
        check("hold_flags",  64'(rsp_flags),  64'(h_flags));
        check("hold_tag",    64'(rsp_tag),    64'(h_tag));
      end
      if (rsp_valid && rsp_ready) begin
        hold = 1'b0;
        if (sb.size() == 0) begin
          check("unexpected_rsp", 64'(rsp_tag), 64'hDEAD);
        end else begin
          e = sb.pop_front();
          check("rsp_result", 64'(rsp_result), 64'(e.res));
          check("rsp_flags",  64'(rsp_flags),  64'(e.flags));
          check("rsp_tag",    64'(rsp_tag),    64'(e.tag));
        end
        n_rsp++;
        last_tag = rsp_tag;
      end else if (rsp_valid) begin
        hold = 1'b1; h_res = rsp_result; h_flags = rsp_flags; h_tag = rsp_tag;
      end else begin
        hold = 1'b0;
      end
      if (req_valid && req_ready) begin
        alu_model(req_op, req_funct, req_shamt, req_imm, req_a, req_b, e.res, e.flags);
        e.tag = m_tag;
        sb.push_back(e);
        m_tag = m_tag + 4'd1;
        n_acc++;
      end
    end
  end

  task automatic set_req(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] sh,
                         input logic [15:0] imm, input logic [31:0] a, input logic [31:0] b);
    req_op = op; req_funct = fn; req_shamt = sh; req_imm = imm; req_a = a; req_b = b;
  endtask

  task automatic rand_req();
    logic [5:0]  fn;
    logic [31:0] a = $urandom;
    logic [31:0] b = $urandom;
    case ($urandom_range(0, 12))
      0: fn = 6'h00;  1: fn = 6'h02;  2: fn = 6'h03;  3: fn = 6'h20;
      4: fn = 6'h21;  5: fn = 6'h22;  6: fn = 6'h23;  7: fn = 6'h24;
      8: fn = 6'h25;  9: fn = 6'h26; 10: fn = 6'h27; 11: fn = 6'h2A;
      default: fn = 6'h2B;
    endcase
    case ($urandom_range(0, 5))
      0: a = 32'h7FFFFFFF;
      1: a = 32'h80000000;
      2: b = a;
      default: ;
    endcase
    set_req(($urandom_range(0, 1) == 0) ? 6'd0 : 6'($urandom_range(8, 15)),
            fn, 5'($urandom), 16'($urandom), a, b);
  endtask

  task automatic send();
    int n = 0;
    req_valid = 1'b1;
    @(negedge clk);
    while (!req_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (n >= 200) check("send_timeout", 64'(req_ready), 64'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    sb.delete();
    m_tag = 4'd0;
    @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc0;
    int rsp0;
    int n;
    rst = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
    set_req(6'd0, 6'd0, 5'd0, 16'd0, 32'd0, 32'd0);
    #2;
    check("rst_count",     64'(count),      64'd0);
    check("rst_rsp_valid", 64'(rsp_valid),  64'd0);
    check("rst_result",    64'(rsp_result), 64'd0);
    check("rst_flags",     64'(rsp_flags),  64'd0);
    check("rst_tag",       64'(rsp_tag),    64'd0);
    check("rst_req_ready", 64'(req_ready),  64'd1);
    @(posedge clk); #1;
    rst = 1'b0;

    // Single add, then signed overflow.
    rsp_ready = 1'b1;
    set_req(6'd0, 6'b100000, 5'd0, 16'd0, -32'sd10, 32'd10);
    send();
    @(posedge clk); #1;
    check("add_valid",  64'(rsp_valid),  64'd1);
    check("add_result", 64'(rsp_result), 64'd0);
    check("add_flags",  64'(rsp_flags),  64'b100);
    check("add_tag",    64'(rsp_tag),    64'd0);
    set_req(6'd0, 6'b100000, 5'd0, 16'd0, 32'h7FFFFFFF, 32'd1);
    send();
    @(posedge clk); #1;
    check("ovf_result", 64'(rsp_result), 64'h80000000);
    check("ovf_flags",  64'(rsp_flags),  64'b011);
    check("ovf_tag",    64'(rsp_tag),    64'd1);

    // Backpressure fill, then pop while full.
    do_reset();
    rsp_ready = 1'b0;
    acc0 = n_acc;
    set_req(6'h0D, 6'd0, 5'd0, 16'h1234, 32'hA5A50000, 32'd0);
    req_valid = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    check("bp_accepted",  64'(n_acc - acc0), 64'd5);
    check("bp_count",     64'(count),        64'd4);
    check("bp_req_ready", 64'(req_ready),    64'd0);
    check("bp_rsp_valid", 64'(rsp_valid),    64'd1);
    check("bp_tag0",      64'(rsp_tag),      64'd0);
    rsp_ready = 1'b1;
    #1;
    check("full_pop_ready", 64'(req_ready), 64'd0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("full_pop_count", 64'(count),   64'd3);
    check("drain_tag1",     64'(rsp_tag), 64'd1);
    for (int i = 2; i <= 4; i++) begin
      @(posedge clk); #1;
      check("drain_valid", 64'(rsp_valid), 64'd1);
      check("drain_tag",   64'(rsp_tag),   64'(i));
    end
    @(posedge clk); #1;
    check("drain_done_valid", 64'(rsp_valid), 64'd0);
    check("drain_done_count", 64'(count),     64'd0);

    // Tag wrap over 17 back-to-back requests.
    do_reset();
    rsp_ready = 1'b1;
    rsp0 = n_rsp;
    repeat (17) begin
      rand_req();
      send();
    end
    repeat (2) @(posedge clk);
    #1;
    check("wrap_rsp_count", 64'(n_rsp - rsp0), 64'd17);
    check("wrap_last_tag",  64'(last_tag),     64'd0);

    // Reset with entries queued and a held response.
    do_reset();
    rsp_ready = 1'b0;
    repeat (4) begin
      rand_req();
      send();
    end
    check("mid_count", 64'(count),     64'd3);
    check("mid_valid", 64'(rsp_valid), 64'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_valid", 64'(rsp_valid), 64'd0);
    check("mid_rst_count", 64'(count),     64'd0);
    check("mid_rst_ready", 64'(req_ready), 64'd1);
    sb.delete();
    m_tag = 4'd0;
    @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("post_rst_idle", 64'(rsp_valid), 64'd0);
    set_req(6'd0, 6'b100000, 5'd0, 16'd0, 32'd5, 32'd6);
    send();
    @(posedge clk); #1;
    check("post_rst_tag",    64'(rsp_tag),    64'd0);
    check("post_rst_result", 64'(rsp_result), 64'd11);

    // Random traffic with random backpressure.
    repeat (400) begin
      rand_req();
      req_valid = ($urandom_range(0, 9) < 7);
      rsp_ready = ($urandom_range(0, 9) < 6);
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    n = 0;
    while ((sb.size() != 0 || rsp_valid) && n < 50) begin
      n++;
      @(posedge clk); #1;
    end
    check("final_drain", 64'(sb.size()), 64'd0);
    check("final_count", 64'(count),     64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/alu_issue_queue.md
ALU_ISSUE_QUEUE -- requirements
Module: alu_issue_queue

Interface
REQ-001 Parameter DEPTH, default 4, number of buffered request entries (power of two, >=2).
REQ-002 Parameter TAGW, default 4, width of the request sequence tag.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 req_valid  input  1  request present.
REQ-006 req_ready  output  1  queue can accept a request this cycle.
REQ-007 req_op  input  6  opcode field, instruction bits [31:26].
REQ-008 req_funct  input  6  function field, R-type instruction bits [5:0].
REQ-009 req_shamt  input  5  shift amount, R-type instruction bits [10:6].
REQ-010 req_imm  input  16  immediate, I-type instruction bits [15:0].
REQ-011 req_a  input  32  operand driven to ALU regA.
REQ-012 req_b  input  32  operand driven to ALU regB.
REQ-013 rsp_valid  output  1  response held in output register.
REQ-014 rsp_ready  input  1  consumer accepts response.
REQ-015 rsp_result  output  32  ALU result.
REQ-016 rsp_flags  output  3  {zero, negative, overflow}, same order as the ALU flags output.
REQ-017 rsp_tag  output  TAGW  sequence tag of the request that produced the response.
REQ-018 count  output  clog2(DEPTH)+1  number of occupied queue entries.

Function
REQ-019 Request accepted on a rising edge where req_valid and req_ready are both high; response delivered on an edge where rsp_valid and rsp_ready are both high.
REQ-020 req_ready SHALL equal (count < DEPTH), with no same-cycle pass-through when full, even if a pop occurs in that cycle.
REQ-021 Encoding: op==0 -> instruction = {op, 5'd0 rs, 5'd1 rt, 5'd8 rd, shamt, funct}; op!=0 -> {op, 5'd0, 5'd1, imm}.
REQ-022 Encoded instruction, a, b and tag SHALL be stored as one FIFO entry; tag = free-running TAGW-bit counter incremented per accepted request, wrapping all-ones -> 0.
REQ-023 Head entry drives the ALU instance combinationally; head pops and the ALU result/flags/tag load the output register on an edge where count>0 and (rsp_valid==0 or rsp_ready==1).
REQ-024 Latency: request accepted at edge E into an empty queue with free output slot yields rsp_valid high after edge E+1.
REQ-025 Sustained throughput: one response per cycle when req_valid and rsp_ready stay high.
REQ-026 rsp_valid held high with result/flags/tag stable until handshake; rsp_valid falls after a handshake edge if no pop occurs on that edge.
REQ-027 Simultaneous push and pop: count unchanged; pointers both advance, wrapping modulo DEPTH.
REQ-028 Responses SHALL leave in acceptance order; no entry dropped or duplicated.
REQ-029 rsp_* outputs and req_ready are register- or count-derived only (no combinational path from rsp_ready to req_ready).

Reset
REQ-030 On rst high: count=0, pointers=0, tag counter=0, rsp_valid=0, rsp_result=0, rsp_flags=0, rsp_tag=0, req_ready=1.
REQ-031 Reset mid-operation discards all queued entries and the held response immediately; no response emitted after release until a new request is accepted.

Structure
REQ-032 Shared package holds: opcode/funct field position constants, the fixed rs/rt/rd register numbers, flag bit indices (ZERO=2, NEG=1, OVF=0).
REQ-033 Existing alu module instantiated once as the only sub-module; FIFO storage and control are inline.

Verification
REQ-034 Single add: op=0, funct=6'b100000, a=-10, b=10, rsp_ready=1 -> one cycle after acceptance, rsp_result=0, rsp_flags=3'b100, rsp_tag=0.
REQ-035 Overflow: op=0, funct=add, a=32'h7FFFFFFF, b=1 -> rsp_result=32'h80000000, rsp_flags=3'b011.
REQ-036 Backpressure: rsp_ready=0, push 6 requests -> 5 accepted (4 queued + 1 in output), req_ready low, count=4; then rsp_ready=1 -> tags 0..4 in order, one per cycle.
REQ-037 Tag wrap: 17 back-to-back requests -> tags 0..15 then 0.
REQ-038 Full with simultaneous pop: count=4, rsp_ready=1, req_valid=1 -> req_ready stays 0 that cycle, count becomes 3.
REQ-039 Reset mid-stream: 3 entries queued, rsp_valid=1, assert rst -> rsp_valid=0, count=0 immediately; first post-reset request returns tag 0.
